// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard scan-code port: receiver states,
// the keyboard word address, common scan codes and dout bit positions.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic [31:0] KBD_ADDR = 32'hA000_0000;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  localparam int READY_BIT = 31;
  localparam int OVF_BIT   = 8;

  // Odd parity holds when the data bits and the parity bit XOR to 1.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous circular-buffer FIFO for received scan-code bytes.
// Pointers carry one extra wrap bit so full and empty are told apart.
// A pop in the same cycle as a push on a full FIFO frees the slot first.
module ps2_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_pop_ok;
  logic             w_push_ok;

  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);
  assign head      = r_mem[r_rptr[AW-1:0]];

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= din;
  end

  // Pointer update; the wrap bit rolls naturally modulo 2*DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_scancode_port.sv
// PS/2 device-to-host receiver feeding a scan-code FIFO, presented as the
// CPU keyboard word {ready, 22'b0, overflow, byte}.
// Optional macro PS2_PARITY_CHECK_EN: when defined, frames must carry odd
// parity; when undefined the parity bit is clocked past but ignored.
module ps2_scancode_port
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        rd,
  output logic [31:0] dout,
  output logic        ready,
  output logic        overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  rx_state_t              r_state;
  logic [2:0]             r_cnt;
  logic [TW-1:0]          r_to;
  logic [7:0]             r_shift;
  logic                   r_push;
  logic                   r_ovf;
`ifdef PS2_PARITY_CHECK_EN
  logic                   r_par;
`endif

  logic       w_fall;
  logic       w_bit;
  logic       w_par_ok;
  logic       w_timeout;
  logic       w_pop;
  logic       w_drop;
  logic       w_full;
  logic       w_empty;
  logic [7:0] w_head;

  // Stage 0 is nearest the pin; the edge is seen between the two oldest stages.
  assign w_fall    = r_clk_sync[SYNC_STAGES-1] & ~r_clk_sync[SYNC_STAGES-2];
  assign w_bit     = r_data_sync[SYNC_STAGES-2];
  assign w_timeout = (r_state != IDLE) && !w_fall && (r_to == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
  assign w_par_ok = odd_parity_ok(r_shift, r_par);
`else
  assign w_par_ok = 1'b1;
`endif

  // Synchronise both PS/2 lines; reset to the idle-high level so no false edge appears.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Receiver FSM with frame timeout; r_push pulses for one cycle per accepted frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_to    <= '0;
      r_shift <= '0;
      r_push  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_push <= 1'b0;
      if (w_timeout) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_to    <= '0;
      end else begin
        if (r_state == IDLE || w_fall) r_to <= '0;
        else                           r_to <= r_to + TW'(1);
        if (w_fall) begin
          case (r_state)
            IDLE: begin
              if (!w_bit) begin
                r_state <= SHIFT;
                r_cnt   <= '0;
              end
            end
            SHIFT: begin
              r_shift <= {w_bit, r_shift[7:1]};
              r_cnt   <= r_cnt + 3'd1;
              if (r_cnt == 3'd7) r_state <= PARITY;
            end
            PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
              r_par   <= w_bit;
`endif
              r_state <= STOP;
            end
            STOP: begin
              r_push  <= w_bit & w_par_ok;
              r_state <= IDLE;
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  assign w_pop  = rd & ~w_empty;
  assign w_drop = r_push & w_full & ~w_pop;

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (r_push),
    .din   (r_shift),
    .pop   (w_pop),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // Sticky overflow: set by a dropped byte, cleared by the next successful pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
    else if (w_pop)  r_ovf <= 1'b0;
  end

  assign ready    = ~w_empty;
  assign overflow = r_ovf;

  // Keyboard word straight from the FIFO head; all zero while nothing is buffered.
  always_comb begin
    dout = '0;
    if (ready) begin
      dout[READY_BIT] = 1'b1;
      dout[OVF_BIT]   = r_ovf;
      dout[7:0]       = w_head;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_port.sv
// Self-checking bench for ps2_scancode_port: directed scenarios plus random
// frames against a frame-level queue model of the keyboard word.
module tb_ps2_scancode_port;

  localparam int DEPTH = 8;
  localparam int TO    = 200;
  localparam int SYNC  = 3;
  localparam int HP    = 20;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic        rd;
  logic [31:0] dout;
  logic        ready;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  mq[$];
  bit          m_ovf;
  logic [31:0] coll_word;

  always #5 clock = ~clock;

  ps2_scancode_port #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rd       (rd),
    .dout     (dout),
    .ready    (ready),
    .overflow (overflow)
  );

  function automatic void model_push(input logic [7:0] b);
    if (mq.size() == DEPTH) m_ovf = 1'b1;
    else mq.push_back(b);
  endfunction

  function automatic logic [31:0] model_read();
    logic [31:0] r;
    if (mq.size() == 0) return 32'h0;
    r = {1'b1, 22'b0, m_ovf, mq[0]};
    void'(mq.pop_front());
    m_ovf = 1'b0;
    return r;
  endfunction

  function automatic bit frame_ok(input bit bad_par, input bit bad_stop);
    return !bad_stop && !(bad_par && PAR_EN);
  endfunction

  // Drive nedges bits of a frame (start, 8 data LSB first, parity, stop).
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nedges, input bit collide);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nedges; i++) begin
      ps2_data = bits[i];
      repeat (HP) @(negedge clock);
      ps2_clk = 1'b0;
      if (collide && i == 10) begin
        repeat (SYNC) @(negedge clock);
        coll_word = dout;
        rd = 1'b1;
        @(negedge clock);
        rd = 1'b0;
        repeat (HP - SYNC - 1) @(negedge clock);
      end else begin
        repeat (HP) @(negedge clock);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HP) @(negedge clock);
  endtask

  task automatic read_word(output logic [31:0] w);
    @(negedge clock);
    w = dout;
    rd = 1'b1;
    @(negedge clock);
    rd = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd = 1'b0;
    mq.delete(); m_ovf = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({ready, overflow, dout} !== 34'h0) $display("FAIL reset_in got ready=%b ovf=%b dout=%h exp 0/0/0", ready, overflow, dout);
    else n_pass++;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({ready, overflow, dout} !== 34'h0) $display("FAIL reset_out got ready=%b ovf=%b dout=%h exp 0/0/0", ready, overflow, dout);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [31:0] w, e;
    send_frame(8'h1C, 0, 0, 11, 0);
    model_push(8'h1C);
    n_checks++;
    if (ready !== 1'b1 || dout !== 32'h8000_001C) $display("FAIL single_word got ready=%b dout=%h exp 1/8000001c", ready, dout);
    else n_pass++;
    read_word(w);
    e = model_read();
    n_checks++;
    if (w !== e) $display("FAIL single_read got %h exp %h", w, e);
    else n_pass++;
    n_checks++;
    if (ready !== 1'b0 || dout !== 32'h0) $display("FAIL single_empty got ready=%b dout=%h exp 0/0", ready, dout);
    else n_pass++;
  endtask

  task automatic test_break();
    logic [31:0] w;
    send_frame(8'hF0, 0, 0, 11, 0);
    send_frame(8'h1C, 0, 0, 11, 0);
    model_push(8'hF0); model_push(8'h1C);
    read_word(w);
    void'(model_read());
    n_checks++;
    if (w !== 32'h8000_00F0) $display("FAIL break_first got %h exp 800000f0", w);
    else n_pass++;
    read_word(w);
    void'(model_read());
    n_checks++;
    if (w !== 32'h8000_001C) $display("FAIL break_second got %h exp 8000001c", w);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [31:0] w, e;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      send_frame(8'(i), 0, 0, 11, 0);
      model_push(8'(i));
    end
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", overflow);
    else n_pass++;
    read_word(w);
    e = model_read();
    n_checks++;
    if (w !== 32'h8000_0101 || w !== e) $display("FAIL ovf_first got %h exp 80000101", w);
    else n_pass++;
    for (int i = 2; i <= DEPTH; i++) begin
      read_word(w);
      e = model_read();
      n_checks++;
      if (w !== e) $display("FAIL ovf_read%0d got %h exp %h", i, w, e);
      else n_pass++;
    end
    n_checks++;
    if (ready !== 1'b0 || overflow !== 1'b0) $display("FAIL ovf_drained got ready=%b ovf=%b exp 0/0", ready, overflow);
    else n_pass++;
  endtask

  task automatic test_parity();
    logic [31:0] w, e;
    send_frame(8'h1C, 1, 0, 11, 0);
    if (frame_ok(1, 0)) model_push(8'h1C);
    read_word(w);
    e = model_read();
    n_checks++;
    if (w !== e) $display("FAIL parity_frame got %h exp %h", w, e);
    else n_pass++;
    send_frame(8'h1C, 0, 1, 11, 0);
    n_checks++;
    if (ready !== 1'b0) $display("FAIL framing_err got ready=%b exp 0", ready);
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic [31:0] w;
    send_frame(8'hFF, 0, 0, 4, 0);
    repeat (TO + 50) @(negedge clock);
    n_checks++;
    if (ready !== 1'b0) $display("FAIL timeout_idle got ready=%b exp 0", ready);
    else n_pass++;
    send_frame(8'h5A, 0, 0, 11, 0);
    read_word(w);
    n_checks++;
    if (w !== 32'h8000_005A) $display("FAIL timeout_recover got %h exp 8000005a", w);
    else n_pass++;
    n_checks++;
    if (ready !== 1'b0) $display("FAIL timeout_extra got ready=%b exp 0", ready);
    else n_pass++;
  endtask

  task automatic test_collision_reset();
    logic [31:0] w, e;
    logic [7:0]  b;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 0, 0, 11, 0);
      model_push(b);
    end
    b = 8'($urandom);
    send_frame(b, 0, 0, 11, 1);
    e = model_read();
    model_push(b);
    n_checks++;
    if (coll_word !== e) $display("FAIL coll_pop got %h exp %h", coll_word, e);
    else n_pass++;
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL coll_ovf got %b exp 0", overflow);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      read_word(w);
      e = model_read();
      n_checks++;
      if (w !== e) $display("FAIL coll_read%0d got %h exp %h", i, w, e);
      else n_pass++;
    end
    n_checks++;
    if (ready !== 1'b0) $display("FAIL coll_empty got ready=%b exp 0", ready);
    else n_pass++;
    send_frame(8'h44, 0, 0, 11, 0);
    send_frame(8'h77, 0, 0, 5, 0);
    #3 reset = 1'b1;
    #1;
    mq.delete(); m_ovf = 1'b0;
    n_checks++;
    if ({ready, overflow, dout} !== 34'h0) $display("FAIL async_reset got ready=%b ovf=%b dout=%h exp 0/0/0", ready, overflow, dout);
    else n_pass++;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    send_frame(8'h33, 0, 0, 11, 0);
    read_word(w);
    n_checks++;
    if (w !== 32'h8000_0033) $display("FAIL after_reset got %h exp 80000033", w);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] w, e;
    logic [7:0]  b;
    int          kind;
    bit          bp, bs;
    for (int it = 0; it < 40; it++) begin
      b = 8'($urandom);
      kind = $urandom_range(0, 9);
      bp = (kind == 0);
      bs = (kind == 1);
      send_frame(b, bp, bs, 11, 0);
      if (frame_ok(bp, bs)) model_push(b);
      for (int r = 0; r < $urandom_range(0, 2); r++) begin
        read_word(w);
        e = model_read();
        n_checks++;
        if (w !== e) $display("FAIL rand_read it=%0d got %h exp %h", it, w, e);
        else n_pass++;
      end
    end
    for (int r = 0; r <= DEPTH; r++) begin
      read_word(w);
      e = model_read();
      n_checks++;
      if (w !== e) $display("FAIL rand_drain%0d got %h exp %h", r, w, e);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_break();
    test_overflow();
    test_parity();
    test_timeout();
    test_collision_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
